ps2_rx_frame: RTL and testbench

//   Receives device-to-host PS/2 frames from the mouse and hands each one over as an
//   11-bit word with a single-cycle valid strobe. Sits directly upstream of the mouse

---
 rtl/ps2_rx_frame.sv | 191 +++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
//   Device-to-host PS/2 frame receiver. Synchronises both PS/2 pins, glitch
//   filters the PS/2 clock, shifts one bit per filtered falling edge, and
//   hands each completed 11-bit frame to the mouse control FSM together with
//   a one-cycle data_flag strobe and a frame error flag. Frames that stall
//   for more than TIMEOUT_CYCLES between falling edges are silently dropped.
//
// Ports
//   clk_25MHz  in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   ps2_clk    in   1   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   1   raw PS/2 data pin (asynchronous)
//   inhibit    in   1   host transmitter owns the bus; receiver held idle
//   rx_data    out  11  last frame: [0]=start [8:1]=data LSB..MSB [9]=parity [10]=stop
//   data_flag  out  1   one-cycle strobe: rx_data and err updated this cycle
//   err        out  1   error flag for the current rx_data, held until next frame
//   busy       out  1   frame reception in progress
// ----------------------------------------------------------------------------
module ps2_rx_frame #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        inhibit,
    output logic [10:0] rx_data,
    output logic        data_flag,
    output logic        err,
    output logic        busy
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

    // A frame is bad on parity failure, a low stop bit, or a high start bit.
    function automatic logic frame_error(input logic [10:0] frame);
        return ~odd_parity_ok(frame[9:1]) | ~frame[10] | frame[0];
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   filt_clk_r;
    logic                   filt_prev_r;
    logic [FILT_W-1:0]      filt_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic [3:0]             count_r;
    logic [10:0]            shift_r;
    logic [10:0]            rx_data_r;
    logic                   data_flag_r;
    logic                   err_r;
    logic                   busy_r;
    state_t                 state_r;

    logic clk_synced_s;
    logic data_bit_s;
    logic fall_s;

    assign clk_synced_s = clk_sync_r[SYNC_STAGES-1];
    assign data_bit_s   = data_sync_r[SYNC_STAGES-1];
    // A fall is seen in the cycle after the filtered clock has dropped to 0.
    assign fall_s       = filt_prev_r & ~filt_clk_r;

    assign rx_data   = rx_data_r;
    assign data_flag = data_flag_r;
    assign err       = err_r;
    assign busy      = busy_r;

    // Metastability synchronisers for both PS/2 pins; idle bus reads as 1.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows the synced clock only after
    // FILTER_LEN consecutive samples that disagree with the current value.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
            filt_cnt_r  <= '0;
        end else begin
            filt_prev_r <= filt_clk_r;
            if (clk_synced_s == filt_clk_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FILT_LAST) begin
                filt_clk_r <= clk_synced_s;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FILT_W'(1);
            end
        end
    end

    // Frame FSM: start detection, bit shifting, timeout abort and hand-over.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 4'd0;
            to_cnt_r    <= '0;
            shift_r     <= 11'd0;
            rx_data_r   <= 11'd0;
            data_flag_r <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else if (inhibit) begin
            // Host owns the bus: drop any partial frame, keep the last word.
            state_r     <= ST_IDLE;
            count_r     <= 4'd0;
            to_cnt_r    <= '0;
            data_flag_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            data_flag_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    to_cnt_r <= '0;
                    // A sampled 1 on a fall is a false start and is ignored.
                    if (fall_s && !data_bit_s) begin
                        shift_r <= {data_bit_s, shift_r[10:1]};
                        count_r <= 4'd1;
                        busy_r  <= 1'b1;
                        state_r <= ST_RECEIVE;
                    end else begin
                        count_r <= 4'd0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RECEIVE: begin
                    busy_r <= 1'b1;
                    // A fall takes priority over an expiring timeout.
                    if (fall_s) begin
                        shift_r  <= {data_bit_s, shift_r[10:1]};
                        to_cnt_r <= '0;
                        if (count_r == 4'd10) begin
                            count_r <= 4'd0;
                            state_r <= ST_DONE;
                        end else begin
                            count_r <= count_r + 4'd1;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r  <= ST_IDLE;
                        count_r  <= 4'd0;
                        to_cnt_r <= '0;
                        busy_r   <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    rx_data_r   <= shift_r;
                    data_flag_r <= 1'b1;
                    err_r       <= frame_error(shift_r);
                    // busy stays high through the data_flag cycle.
                    busy_r      <= 1'b1;
                    count_r     <= 4'd0;
                    to_cnt_r    <= '0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    count_r  <= 4'd0;
                    to_cnt_r <= '0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
module tb_ps2_rx_frame;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic        inhibit;
    logic [10:0] rx_data;
    logic        data_flag;
    logic        err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    // Flag monitor: counts strobe cycles and captures outputs at each strobe.
    int          flag_cnt   = 0;
    logic [10:0] cap_data   = 11'd0;
    logic        cap_err    = 1'b0;
    logic        cap_busy   = 1'b0;
    logic        busy_after = 1'b1;
    logic        flag_prev  = 1'b0;

    ps2_rx_frame #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .inhibit(inhibit),
        .rx_data(rx_data),
        .data_flag(data_flag),
        .err(err),
        .busy(busy)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    always @(negedge clk_25MHz) begin
        if (flag_prev) busy_after = busy;
        if (data_flag) begin
            flag_cnt = flag_cnt + 1;
            cap_data = rx_data;
            cap_err  = err;
            cap_busy = busy;
        end
        flag_prev = data_flag;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(f[i]);
    endtask

    task automatic test_reset;
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; inhibit = 1'b0;
        cyc(5);
        n_vec++; if (rx_data !== 11'd0) begin n_bad++; $display("FAIL reset_rx_data: got %b want %b", rx_data, 11'd0); end
        n_vec++; if (data_flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b want 0", data_flag); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        cyc(5);
    endtask

    task automatic test_single;
        int n0;
        logic [10:0] f;
        n0 = flag_cnt;
        f = make_frame(8'hAA, 1'b0);
        send_bits(f, 0, 4);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_mid: got %b want 1", busy); end
        n_vec++; if (flag_cnt !== n0) begin n_bad++; $display("FAIL single_no_early_flag: got %0d want %0d", flag_cnt, n0); end
        send_bits(f, 5, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL single_flag_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_data !== 11'b11101010100) begin n_bad++; $display("FAIL single_data: got %b want %b", cap_data, 11'b11101010100); end
        n_vec++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", cap_err); end
        n_vec++; if (cap_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_at_flag: got %b want 1", cap_busy); end
        n_vec++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL single_busy_after_flag: got %b want 0", busy_after); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = flag_cnt;
        send_bits(make_frame(8'h00, 1'b0), 0, 10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL b2b_first_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_data !== 11'b11000000000) begin n_bad++; $display("FAIL b2b_first_data: got %b want %b", cap_data, 11'b11000000000); end
        n_vec++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL b2b_first_err: got %b want 0", cap_err); end
        send_bits(make_frame(8'hFA, 1'b0), 0, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 2) begin n_bad++; $display("FAIL b2b_second_count: got %0d want %0d", flag_cnt, n0 + 2); end
        n_vec++; if (cap_data !== 11'b11111110100) begin n_bad++; $display("FAIL b2b_second_data: got %b want %b", cap_data, 11'b11111110100); end
        n_vec++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL b2b_second_err: got %b want 0", cap_err); end
    endtask

    task automatic test_bad_parity;
        int n0;
        logic [10:0] f;
        n0 = flag_cnt;
        send_bits(make_frame(8'hF4, 1'b1), 0, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL parity_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_err !== 1'b1) begin n_bad++; $display("FAIL parity_err: got %b want 1", cap_err); end
        n_vec++; if (cap_data !== 11'b11111101000) begin n_bad++; $display("FAIL parity_data: got %b want %b", cap_data, 11'b11111101000); end
        f = make_frame(8'h00, 1'b0);
        send_bits(f, 0, 4);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL parity_err_held: got %b want 1", err); end
        send_bits(f, 5, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL parity_err_cleared: got %b want 0", err); end
    endtask

    task automatic test_glitch;
        int n0;
        logic [10:0] f;
        n0 = flag_cnt;
        ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(10);
        send_bit(1'b1);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle_busy: got %b want 0", busy); end
        f = make_frame(8'h55, 1'b0);
        send_bits(f, 0, 3);
        ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(10);
        send_bits(f, 4, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL glitch_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_data !== 11'b11010101010) begin n_bad++; $display("FAIL glitch_data: got %b want %b", cap_data, 11'b11010101010); end
        n_vec++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL glitch_err: got %b want 0", cap_err); end
    endtask

    task automatic test_stall;
        int n0;
        n0 = flag_cnt;
        send_bits(make_frame(8'h3C, 1'b0), 0, 4);
        cyc(4900);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy_before_timeout: got %b want 1", busy); end
        cyc(150);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy_after_timeout: got %b want 0", busy); end
        n_vec++; if (flag_cnt !== n0) begin n_bad++; $display("FAIL stall_no_flag: got %0d want %0d", flag_cnt, n0); end
        n_vec++; if (rx_data !== 11'b11010101010) begin n_bad++; $display("FAIL stall_rx_held: got %b want %b", rx_data, 11'b11010101010); end
        send_bits(make_frame(8'hAA, 1'b0), 0, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL stall_next_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_data !== 11'b11101010100) begin n_bad++; $display("FAIL stall_next_data: got %b want %b", cap_data, 11'b11101010100); end
    endtask

    task automatic test_reset_mid;
        int n0;
        n0 = flag_cnt;
        send_bits(make_frame(8'h12, 1'b0), 0, 5);
        reset = 1'b1;
        cyc(1);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_vec++; if (rx_data !== 11'd0) begin n_bad++; $display("FAIL rstmid_rx_data: got %b want %b", rx_data, 11'd0); end
        cyc(1);
        reset = 1'b0;
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0) begin n_bad++; $display("FAIL rstmid_no_flag: got %0d want %0d", flag_cnt, n0); end
        send_bits(make_frame(8'h3C, 1'b0), 0, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL rstmid_next_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_data !== 11'b11001111000) begin n_bad++; $display("FAIL rstmid_next_data: got %b want %b", cap_data, 11'b11001111000); end
    endtask

    task automatic test_inhibit;
        int n0;
        n0 = flag_cnt;
        send_bits(make_frame(8'hA5, 1'b0), 0, 3);
        inhibit = 1'b1;
        cyc(1);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL inhibit_busy: got %b want 0", busy); end
        cyc(20);
        n_vec++; if (rx_data !== 11'b11001111000) begin n_bad++; $display("FAIL inhibit_rx_held: got %b want %b", rx_data, 11'b11001111000); end
        n_vec++; if (flag_cnt !== n0) begin n_bad++; $display("FAIL inhibit_no_flag: got %0d want %0d", flag_cnt, n0); end
        inhibit = 1'b0;
        ps2_data = 1'b1;
        cyc(10);
        send_bits(make_frame(8'hA5, 1'b0), 0, 10);
        ps2_data = 1'b1;
        cyc(10);
        n_vec++; if (flag_cnt !== n0 + 1) begin n_bad++; $display("FAIL inhibit_next_count: got %0d want %0d", flag_cnt, n0 + 1); end
        n_vec++; if (cap_data !== 11'b11101001010) begin n_bad++; $display("FAIL inhibit_next_data: got %b want %b", cap_data, 11'b11101001010); end
        n_vec++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL inhibit_next_err: got %b want 0", cap_err); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_bad_parity;
        test_glitch;
        test_stall;
        test_reset_mid;
        test_inhibit;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
